simt_div_ctrl: RTL and testbench

//  Sequences the per-warp predicate mask stack for IF/ELSE/ENDIF divergence in the SM core scheduler.

---
 rtl/tgpu_simt_pkg.sv | 27 ++
 rtl/simt_div_ctrl.sv | 158 +++++++++++++++
 tb/tb_simt_div_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/tgpu_simt_pkg.sv
// Shared SIMT scheduler definitions: divergence op encoding, default
// warp geometry and the divergence-controller FSM state encoding.
package tgpu_simt_pkg;

  // Default warp geometry used by the SM core scheduler
  localparam int N_CORES     = 4;
  localparam int STACK_DEPTH = 3;
  localparam int PC_W        = 8;

  // Divergence ops as decoded by issue
  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_IF    = 2'd1,
    OP_ELSE  = 2'd2,
    OP_ENDIF = 2'd3
  } op_e;

  // Divergence controller sequencing states
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_EXEC_IF    = 3'd1,
    S_ELSE_POP   = 3'd2,
    S_ELSE_PUSH  = 3'd3,
    S_EXEC_ENDIF = 3'd4
  } div_state_e;

endpackage : tgpu_simt_pkg

// File: rtl/simt_div_ctrl.sv
// Per-warp IF/ELSE/ENDIF divergence sequencer. Drives the push/pop and
// data-in of the predicate mask stack that sits beside it, exports the
// stack top as the active lane mask, and redirects fetch past a branch
// body in which no lane is active.
module simt_div_ctrl
  import tgpu_simt_pkg::*;
#(
  parameter int N_CORES     = tgpu_simt_pkg::N_CORES,
  parameter int STACK_DEPTH = tgpu_simt_pkg::STACK_DEPTH,
  parameter int PC_W        = tgpu_simt_pkg::PC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  // Divergence op handshake from issue
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [1:0]             instr_op,
  input  logic [N_CORES-1:0]     instr_cond,
  input  logic [PC_W-1:0]        instr_target,
  // Fetch redirect
  output logic                   redirect_valid,
  output logic [PC_W-1:0]        redirect_pc,
  // Lane datapath enable
  output logic [N_CORES-1:0]     active_mask,
  // Mask stack controls
  output logic                   ms_push,
  output logic                   ms_pop,
  output logic [N_CORES-1:0]     ms_din,
  input  logic [N_CORES-1:0]     ms_tos,
  // Status
  output logic [STACK_DEPTH-1:0] depth,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam logic [STACK_DEPTH-1:0] DEPTH_FULL = {STACK_DEPTH{1'b1}};
  localparam logic [STACK_DEPTH-1:0] DEPTH_ONE  = {{(STACK_DEPTH-1){1'b0}}, 1'b1};

  div_state_e             state_q, state_d;
  logic [N_CORES-1:0]     cond_q, cond_d;
  logic [PC_W-1:0]        target_q, target_d;
  logic [N_CORES-1:0]     if_mask_q, if_mask_d;
  logic [STACK_DEPTH-1:0] depth_q, depth_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic [N_CORES-1:0]     new_mask;
  op_e                    op_in;

  assign op_in         = op_e'(instr_op);
  assign active_mask   = ms_tos;
  assign depth         = depth_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  // Redirect address is the target captured when the op was accepted
  assign redirect_pc   = target_q;

  // State, operand latches, nesting depth and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cond_q    <= '0;
      target_q  <= '0;
      if_mask_q <= '0;
      depth_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cond_q    <= cond_d;
      target_q  <= target_d;
      if_mask_q <= if_mask_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Next-state sequencing and stack strobes; ops at a depth boundary
  // are retired in IDLE without touching the stack
  always_comb begin
    state_d        = state_q;
    cond_d         = cond_q;
    target_d       = target_q;
    if_mask_d      = if_mask_q;
    depth_d        = depth_q;
    ovf_d          = ovf_q;
    unf_d          = unf_q;
    instr_ready    = 1'b0;
    ms_push        = 1'b0;
    ms_pop         = 1'b0;
    ms_din         = '0;
    redirect_valid = 1'b0;
    new_mask       = '0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          cond_d   = instr_cond;
          target_d = instr_target;
          case (op_in)
            OP_IF: begin
              if (depth_q == DEPTH_FULL) ovf_d = 1'b1;
              else                       state_d = S_EXEC_IF;
            end
            OP_ELSE: begin
              if (depth_q == '0) unf_d = 1'b1;
              else               state_d = S_ELSE_POP;
            end
            OP_ENDIF: begin
              if (depth_q == '0) unf_d = 1'b1;
              else               state_d = S_EXEC_ENDIF;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_EXEC_IF: begin
        // Taken lanes are those active now with the condition true;
        // the push happens even when empty so ENDIF stays balanced
        new_mask       = ms_tos & cond_q;
        ms_push        = 1'b1;
        ms_din         = new_mask;
        if_mask_d      = new_mask;
        depth_d        = depth_q + DEPTH_ONE;
        redirect_valid = (new_mask == '0);
        state_d        = S_IDLE;
      end

      S_ELSE_POP: begin
        // Drop the IF level so the parent mask appears on ms_tos
        ms_pop  = 1'b1;
        depth_d = depth_q - DEPTH_ONE;
        state_d = S_ELSE_PUSH;
      end

      S_ELSE_PUSH: begin
        // Else lanes: parent lanes that did not take the IF
        new_mask       = ms_tos & ~if_mask_q;
        ms_push        = 1'b1;
        ms_din         = new_mask;
        depth_d        = depth_q + DEPTH_ONE;
        redirect_valid = (new_mask == '0);
        state_d        = S_IDLE;
      end

      S_EXEC_ENDIF: begin
        ms_pop  = 1'b1;
        depth_d = depth_q - DEPTH_ONE;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule : simt_div_ctrl

// File: tb/tb_simt_div_ctrl.sv
// Directed bench for simt_div_ctrl with a behavioural mask stack wired to
// its push/pop/din/tos ports.
module tb_simt_div_ctrl;
  import tgpu_simt_pkg::*;

  localparam int N  = 4;
  localparam int SD = 3;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    instr_op;
  logic [N-1:0]  instr_cond;
  logic [PW-1:0] instr_target;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic [N-1:0]  active_mask;
  logic          ms_push;
  logic          ms_pop;
  logic [N-1:0]  ms_din;
  logic [N-1:0]  ms_tos;
  logic [SD-1:0] depth;
  logic          err_overflow;
  logic          err_underflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simt_div_ctrl #(.N_CORES(N), .STACK_DEPTH(SD), .PC_W(PW)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_cond(instr_cond), .instr_target(instr_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .active_mask(active_mask),
    .ms_push(ms_push), .ms_pop(ms_pop), .ms_din(ms_din), .ms_tos(ms_tos),
    .depth(depth), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  // Mask stack model: entry 0 is the all-ones base mask
  logic [N-1:0]  stk [1:7];
  logic [SD-1:0] sp;

  assign ms_tos = (sp == '0) ? {N{1'b1}} : stk[sp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        sp <= '0;
    else if (ms_push) sp <= sp + 3'd1;
    else if (ms_pop)  sp <= sp - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset && ms_push && (sp != 3'd7)) stk[sp + 3'd1] <= ms_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one op; returns two time units after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [N-1:0] cond, input logic [PW-1:0] tgt);
    instr_valid  = 1'b1;
    instr_op     = op;
    instr_cond   = cond;
    instr_target = tgt;
    @(posedge clk);
    #1;
    instr_valid  = 1'b0;
    instr_op     = OP_NOP;
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    instr_valid  = 1'b0;
    instr_op     = OP_NOP;
    instr_cond   = '0;
    instr_target = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    // 1. Reset state
    chk("rst_ready", instr_ready, 1);
    chk("rst_mask", active_mask, 4'b1111);
    chk("rst_depth", depth, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_unf", err_underflow, 0);
    chk("rst_redir", redirect_valid, 0);
    chk("rst_push", ms_push, 0);

    // NOP retires in one cycle with no stack activity
    issue(OP_NOP, 4'b1111, 8'h00);
    chk("nop_ready", instr_ready, 1);
    chk("nop_push", ms_push, 0);
    chk("nop_pop", ms_pop, 0);

    // 2. IF 0101
    issue(OP_IF, 4'b0101, 8'h10);
    chk("if_push", ms_push, 1);
    chk("if_din", ms_din, 4'b0101);
    chk("if_pop", ms_pop, 0);
    chk("if_ready", instr_ready, 0);
    chk("if_redir", redirect_valid, 0);
    tick();
    chk("if_mask", active_mask, 4'b0101);
    chk("if_depth", depth, 1);
    chk("if_ready2", instr_ready, 1);
    chk("if_push_off", ms_push, 0);

    // 3. ELSE: pop then push complement within parent
    issue(OP_ELSE, 4'b0000, 8'h20);
    chk("else_pop", ms_pop, 1);
    chk("else_pop_push", ms_push, 0);
    chk("else_pop_ready", instr_ready, 0);
    tick();
    chk("else_push", ms_push, 1);
    chk("else_push_pop", ms_pop, 0);
    chk("else_din", ms_din, 4'b1010);
    chk("else_push_ready", instr_ready, 0);
    chk("else_redir", redirect_valid, 0);
    tick();
    chk("else_mask", active_mask, 4'b1010);
    chk("else_depth", depth, 1);
    chk("else_ready", instr_ready, 1);

    // 4. Empty IF redirects fetch
    issue(OP_IF, 4'b0000, 8'h40);
    chk("skip_redir", redirect_valid, 1);
    chk("skip_pc", redirect_pc, 8'h40);
    chk("skip_push", ms_push, 1);
    chk("skip_din", ms_din, 4'b0000);
    tick();
    chk("skip_redir_off", redirect_valid, 0);
    chk("skip_depth", depth, 2);
    chk("skip_mask", active_mask, 4'b0000);
    issue(OP_ENDIF, 4'b0000, 8'h00);
    chk("skip_endif_pop", ms_pop, 1);
    tick();
    chk("skip_endif_mask", active_mask, 4'b1010);
    chk("skip_endif_depth", depth, 1);
    issue(OP_ENDIF, 4'b0000, 8'h00);
    tick();
    chk("close_mask", active_mask, 4'b1111);
    chk("close_depth", depth, 0);

    // 5. Nested IFs
    issue(OP_IF, 4'b0011, 8'h50);
    tick();
    issue(OP_IF, 4'b0110, 8'h60);
    chk("nest_din", ms_din, 4'b0010);
    tick();
    chk("nest_mask", active_mask, 4'b0010);
    chk("nest_depth", depth, 2);
    issue(OP_ENDIF, 4'b0000, 8'h00);
    tick();
    chk("nest_end1_mask", active_mask, 4'b0011);
    chk("nest_end1_depth", depth, 1);
    issue(OP_ENDIF, 4'b0000, 8'h00);
    tick();
    chk("nest_end2_mask", active_mask, 4'b1111);
    chk("nest_end2_depth", depth, 0);

    // 6a. Overflow at full depth
    for (int i = 0; i < 7; i++) begin
      issue(OP_IF, 4'b1111, 8'h70);
      tick();
    end
    chk("full_depth", depth, 7);
    chk("full_ovf", err_overflow, 0);
    issue(OP_IF, 4'b1111, 8'h70);
    chk("ovf_push", ms_push, 0);
    chk("ovf_ready", instr_ready, 1);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_depth", depth, 7);
    tick();
    chk("ovf_sticky", err_overflow, 1);
    chk("ovf_depth2", depth, 7);

    // 6b. Reset clears, then underflow
    reset = 1'b1;
    #1;
    chk("rst2_depth", depth, 0);
    chk("rst2_ovf", err_overflow, 0);
    chk("rst2_mask", active_mask, 4'b1111);
    @(posedge clk);
    #2;
    reset = 1'b0;
    issue(OP_ENDIF, 4'b0000, 8'h00);
    chk("unf_pop", ms_pop, 0);
    chk("unf_flag", err_underflow, 1);
    chk("unf_depth", depth, 0);
    chk("unf_ready", instr_ready, 1);
    issue(OP_ELSE, 4'b0000, 8'h00);
    chk("unf_else_pop", ms_pop, 0);
    chk("unf_else_depth", depth, 0);

    // 6c. Reset during ELSE_POP discards the ELSE
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    issue(OP_IF, 4'b1100, 8'h80);
    tick();
    chk("mid_if_depth", depth, 1);
    issue(OP_ELSE, 4'b0000, 8'h90);
    chk("mid_else_pop", ms_pop, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", instr_ready, 1);
    chk("mid_rst_depth", depth, 0);
    chk("mid_rst_pop", ms_pop, 0);
    chk("mid_rst_mask", active_mask, 4'b1111);
    chk("mid_rst_unf", err_underflow, 0);
    reset = 1'b0;
    tick();
    chk("mid_after_push", ms_push, 0);
    chk("mid_after_ready", instr_ready, 1);
    chk("mid_after_depth", depth, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_simt_div_ctrl
